// File: rtl/e203_exu_flush_ctrl.sv
// Flush arbiter between branch-mispredict and exception/IRQ sources: forms the target PC,
// holds one flush toward the IFU until accepted, and counts accepted flushes per source.
// Optional macro E203_FLUSH_BYPASS_EN enables a same-cycle flush path while IDLE.
module e203_exu_flush_ctrl #(
  parameter int PC_SIZE = 32,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               brchmis_flush_req,
  input  logic [PC_SIZE-1:0] brchmis_flush_add_op1,
  input  logic [PC_SIZE-1:0] brchmis_flush_add_op2,
  output logic               brchmis_flush_ack,
  input  logic               excpirq_flush_req,
  input  logic [PC_SIZE-1:0] excpirq_flush_add_op1,
  input  logic [PC_SIZE-1:0] excpirq_flush_add_op2,
  output logic               excpirq_flush_ack,
  output logic               pipe_flush_req,
  output logic [PC_SIZE-1:0] pipe_flush_pc,
  input  logic               pipe_flush_ack,
  output logic               pipe_flush_busy,
  output logic [CNT_W-1:0]   brchmis_flush_cnt,
  output logic [CNT_W-1:0]   excpirq_flush_cnt
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    PEND = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [PC_SIZE-1:0] pc_q, pc_d;
  logic [CNT_W-1:0]   brch_cnt_q, brch_cnt_d;
  logic [CNT_W-1:0]   excp_cnt_q, excp_cnt_d;
  logic               win_req;
  logic [PC_SIZE-1:0] win_sum;
  logic               brch_ack, excp_ack;
  logic               flush_req;
  logic [PC_SIZE-1:0] flush_pc;

  // Arbitration, target adder, next-state and source acks
  always_comb begin
    win_req = excpirq_flush_req | brchmis_flush_req;
    if (excpirq_flush_req) begin
      win_sum = excpirq_flush_add_op1 + excpirq_flush_add_op2;
    end else begin
      win_sum = brchmis_flush_add_op1 + brchmis_flush_add_op2;
    end

    state_d   = state_q;
    pc_d      = pc_q;
    excp_ack  = 1'b0;
    brch_ack  = 1'b0;
    flush_req = 1'b0;
    flush_pc  = pc_q;

    case (state_q)
      IDLE: begin
        // Acks stay low while reset is held so no flush is counted or lost
        if (rst_n && win_req) begin
          excp_ack = excpirq_flush_req;
          brch_ack = brchmis_flush_req & ~excpirq_flush_req;
          pc_d     = win_sum;
`ifdef E203_FLUSH_BYPASS_EN
          flush_req = 1'b1;
          flush_pc  = win_sum;
          if (pipe_flush_ack) begin
            state_d = IDLE;
          end else begin
            state_d = PEND;
          end
`else
          state_d = PEND;
`endif
        end else begin
          state_d = IDLE;
        end
      end
      PEND: begin
        flush_req = 1'b1;
        if (pipe_flush_ack) begin
          state_d = IDLE;
        end else begin
          state_d = PEND;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    brch_cnt_d = brch_cnt_q + {{(CNT_W-1){1'b0}}, brch_ack};
    excp_cnt_d = excp_cnt_q + {{(CNT_W-1){1'b0}}, excp_ack};
  end

  // State, captured PC and wrap-around event counters
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      pc_q       <= {PC_SIZE{1'b0}};
      brch_cnt_q <= {CNT_W{1'b0}};
      excp_cnt_q <= {CNT_W{1'b0}};
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      brch_cnt_q <= brch_cnt_d;
      excp_cnt_q <= excp_cnt_d;
    end
  end

  assign brchmis_flush_ack = brch_ack;
  assign excpirq_flush_ack = excp_ack;
  assign pipe_flush_req    = flush_req;
  assign pipe_flush_pc     = flush_pc;
  assign pipe_flush_busy   = (state_q == PEND);
  assign brchmis_flush_cnt = brch_cnt_q;
  assign excpirq_flush_cnt = excp_cnt_q;

endmodule
